mac_accumulator: RTL

- Sits directly downstream of the INT8 multiplier pipeline.
- Sums a framed stream of signed 16-bit products into a wide signed accumulator, one product per cycle, with no backpressure on the input side.
- Hands each completed dot-product to the consumer through a single-entry valid/ready output register.
- Keeps accumulating the next frame while a result waits to be taken.

---
 rtl/mac_pkg.sv | 20 ++
 rtl/mac_accumulator_sat_adder.sv | 35 +++
 rtl/mac_accumulator.sv | 112 +++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared widths, frame-state enum and result struct for mac_accumulator
package mac_pkg;

  localparam int PROD_W    = 16;
  localparam int ACC_W_DEF = 32;
  localparam int CNT_W_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    OPEN = 1'b1
  } frame_state_t;

  // Completed dot-product at the default widths, for consumers built with the defaults.
  typedef struct packed {
    logic signed [ACC_W_DEF-1:0] sum;
    logic        [CNT_W_DEF-1:0] cnt;
    logic                        sat;
  } mac_result_t;

endpackage

// File: rtl/mac_accumulator_sat_adder.sv
// rtl/mac_accumulator_sat_adder.sv - accumulator + sign-extended product add; clamps when ACC_SATURATE_EN is defined
module sat_adder
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [PROD_W-1:0] prod,
  output logic signed [ACC_W-1:0]  sum,
  output logic                     clamp
);

`ifdef ACC_SATURATE_EN
  logic signed [ACC_W:0] wide;
  logic                  ovf;

  // One guard bit makes overflow visible as a disagreement of the top two bits.
  assign wide = {acc[ACC_W-1], acc} + {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};
  assign ovf  = wide[ACC_W] ^ wide[ACC_W-1];

  // Clamp toward the true sign (guard bit) on overflow.
  always_comb begin
    sum   = wide[ACC_W-1:0];
    clamp = ovf;
    if (ovf) begin
      sum = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  // Wrapping add: the guard bit would be discarded, so add at ACC_W directly.
  assign sum   = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign clamp = 1'b0;
`endif

endmodule

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - framed signed dot-product accumulator with single-entry result register; optional ACC_SATURATE_EN
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_val,
  input  logic signed [PROD_W-1:0] in_prod,
  input  logic                    in_last,
  input  logic                    clr,
  output logic                    out_val,
  input  logic                    out_rdy,
  output logic signed [ACC_W-1:0] out_sum,
  output logic        [CNT_W-1:0] out_cnt,
  output logic                    out_sat,
  output logic                    drop_err
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  frame_state_t            state, state_nxt;
  logic signed [ACC_W-1:0] acc, add_base, add_sum;
  logic        [CNT_W-1:0] cnt, cnt_nxt;
  logic                    sat, sat_nxt, add_clamp;
  logic                    fire, load;

  // A new frame starts from zero, so the adder sees 0 instead of the stale acc in IDLE.
  assign add_base = (state == OPEN) ? acc : '0;

  sat_adder #(.ACC_W(ACC_W)) u_sat_adder (
    .acc   (add_base),
    .prod  (in_prod),
    .sum   (add_sum),
    .clamp (add_clamp)
  );

  // Next frame state, next count/sat, and frame-completion strobe.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = CNT_ONE;
    sat_nxt   = add_clamp;
    fire      = 1'b0;
    if (state == OPEN) begin
      cnt_nxt = (&cnt) ? cnt : cnt + CNT_ONE;
      sat_nxt = sat | add_clamp;
    end
    if (clr) begin
      state_nxt = IDLE;
    end else if (in_val) begin
      if (in_last) begin
        state_nxt = IDLE;
        fire      = 1'b1;
      end else begin
        state_nxt = OPEN;
      end
    end
  end

  // A completed result may take the register when it is empty or being drained this cycle.
  assign load = fire && (!out_val || out_rdy);

  // Frame state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Running accumulator, product count and saturation flag of the open frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      cnt <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
      sat <= 1'b0;
    end else if (in_val) begin
      acc <= add_sum;
      cnt <= cnt_nxt;
      sat <= sat_nxt;
    end
  end

  // Single-entry output register; contents hold while waiting for out_rdy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_val <= 1'b0;
      out_sum <= '0;
      out_cnt <= '0;
      out_sat <= 1'b0;
    end else if (load) begin
      out_val <= 1'b1;
      out_sum <= add_sum;
      out_cnt <= cnt_nxt;
      out_sat <= sat_nxt;
    end else if (out_val && out_rdy) begin
      out_val <= 1'b0;
    end
  end

  // Sticky flag for a completed frame that found the register still occupied.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              drop_err <= 1'b0;
    else if (clr)          drop_err <= 1'b0;
    else if (fire && !load) drop_err <= 1'b1;
  end

endmodule
